// File: rtl/rx_libnet_mc.sv
// Receive-side libnet stage: per-channel sequence tracking, in-order forwarding,
// SYN resync, and a registered ack/NAK stream with full backpressure.
module rx_libnet_mc #(
  parameter int unsigned DATA_WIDTH   = 512,
  parameter int unsigned USER_WIDTH   = 64,
  parameter int unsigned NUM_CHAN     = 4,
  parameter int unsigned SEQ_LSB      = 344,
  parameter int unsigned SYN_BIT      = 377,
  parameter int unsigned CHAN_LSB     = 378,
  parameter bit          STRIP_HEADER = 1'b0
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [DATA_WIDTH-1:0]   rx_tdata,
  input  logic [DATA_WIDTH/8-1:0] rx_tkeep,
  input  logic [USER_WIDTH-1:0]   rx_tuser,
  input  logic                    rx_tlast,
  input  logic                    rx_tvalid,
  output logic                    rx_tready,
  output logic [DATA_WIDTH-1:0]   tx_tdata,
  output logic [DATA_WIDTH/8-1:0] tx_tkeep,
  output logic [USER_WIDTH-1:0]   tx_tuser,
  output logic                    tx_tlast,
  output logic                    tx_tvalid,
  input  logic                    tx_tready,
  output logic [39:0]             ack_tdata,
  output logic                    ack_tvalid,
  input  logic                    ack_tready,
  output logic [31:0]             drop_count
);

  localparam int unsigned ChanW = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1;
  localparam int unsigned KeepW = DATA_WIDTH / 8;

  typedef enum logic [1:0] {StParse, StStream, StDrop} state_e;

  state_e                  state_q, state_d;
  logic [31:0]             exp_q [NUM_CHAN];
  logic [DATA_WIDTH-1:0]   tx_tdata_q;
  logic [KeepW-1:0]        tx_tkeep_q;
  logic [USER_WIDTH-1:0]   tx_tuser_q;
  logic                    tx_tlast_q;
  logic                    tx_tvalid_q, tx_tvalid_d;
  logic [39:0]             ack_tdata_q, ack_tdata_d;
  logic                    ack_tvalid_q, ack_tvalid_d;
  logic [31:0]             drop_count_q, drop_count_d;

  logic              tx_ok, ack_ok, rdy, rx_hs;
  logic [7:0]        hdr_ch;
  logic [31:0]       hdr_seq, exp_cur, exp_wdata;
  logic              hdr_syn, ch_ok, in_order;
  logic [ChanW-1:0]  ch_idx;
  logic              exp_wr, fwd, ack_load, drop_inc;

  always_comb begin
    tx_ok  = !tx_tvalid_q || tx_tready;
    ack_ok = !ack_tvalid_q || ack_tready;
    unique case (state_q)
      StParse:  rdy = ack_ok && tx_ok;
      StStream: rdy = tx_ok;
      default:  rdy = 1'b1;
    endcase
    rx_tready = resetn && rdy;
    rx_hs     = rx_tvalid && rx_tready;
  end

  // Header field decode; only meaningful while in StParse.
  always_comb begin
    hdr_ch   = rx_tdata[CHAN_LSB +: 8];
    hdr_seq  = rx_tdata[SEQ_LSB +: 32];
    hdr_syn  = rx_tdata[SYN_BIT];
    ch_ok    = 32'(hdr_ch) < NUM_CHAN;
    ch_idx   = hdr_ch[ChanW-1:0];
    exp_cur  = ch_ok ? exp_q[ch_idx] : 32'd0;
    in_order = ch_ok && !hdr_syn && (hdr_seq == exp_cur);
  end

  always_comb begin
    state_d      = state_q;
    exp_wr       = 1'b0;
    exp_wdata    = hdr_seq;
    fwd          = 1'b0;
    ack_load     = 1'b0;
    ack_tdata_d  = ack_tdata_q;
    drop_inc     = 1'b0;
    if (rx_hs) begin
      unique case (state_q)
        StParse: begin
          if (!ch_ok) begin
            drop_inc = 1'b1;
          end else if (hdr_syn) begin
            exp_wr      = 1'b1;
            exp_wdata   = hdr_seq;
            ack_load    = 1'b1;
            ack_tdata_d = {1'b0, hdr_ch[6:0], hdr_seq};
          end else if (in_order) begin
            exp_wr      = 1'b1;
            exp_wdata   = hdr_seq + 32'd1;
            ack_load    = 1'b1;
            ack_tdata_d = {1'b0, hdr_ch[6:0], hdr_seq + 32'd1};
            fwd         = !STRIP_HEADER;
          end else begin
            ack_load    = 1'b1;
            ack_tdata_d = {1'b1, hdr_ch[6:0], exp_cur};
            drop_inc    = 1'b1;
          end
          if (!rx_tlast) state_d = in_order ? StStream : StDrop;
        end
        StStream: begin
          fwd = 1'b1;
          if (rx_tlast) state_d = StParse;
        end
        default: begin
          if (rx_tlast) state_d = StParse;
        end
      endcase
    end

    if (fwd)            tx_tvalid_d = 1'b1;
    else if (tx_tready) tx_tvalid_d = 1'b0;
    else                tx_tvalid_d = tx_tvalid_q;

    if (ack_load)        ack_tvalid_d = 1'b1;
    else if (ack_tready) ack_tvalid_d = 1'b0;
    else                 ack_tvalid_d = ack_tvalid_q;

    drop_count_d = drop_count_q;
    if (drop_inc && (drop_count_q != 32'hFFFF_FFFF)) drop_count_d = drop_count_q + 32'd1;
  end

  // Data registers carry no reset; only the valid/control state is cleared.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= StParse;
      for (int i = 0; i < int'(NUM_CHAN); i++) exp_q[i] <= 32'd0;
      tx_tvalid_q  <= 1'b0;
      ack_tvalid_q <= 1'b0;
      drop_count_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      if (exp_wr) exp_q[ch_idx] <= exp_wdata;
      tx_tvalid_q  <= tx_tvalid_d;
      ack_tvalid_q <= ack_tvalid_d;
      drop_count_q <= drop_count_d;
      if (fwd) begin
        tx_tdata_q <= rx_tdata;
        tx_tkeep_q <= rx_tkeep;
        tx_tuser_q <= rx_tuser;
        tx_tlast_q <= rx_tlast;
      end
      if (ack_load) ack_tdata_q <= ack_tdata_d;
    end
  end

  always_comb begin
    tx_tdata   = tx_tdata_q;
    tx_tkeep   = tx_tkeep_q;
    tx_tuser   = tx_tuser_q;
    tx_tlast   = tx_tlast_q;
    tx_tvalid  = tx_tvalid_q;
    ack_tdata  = ack_tdata_q;
    ack_tvalid = ack_tvalid_q;
    drop_count = drop_count_q;
  end

endmodule

// File: tb/tb_rx_libnet_mc.sv
// Directed bench for rx_libnet_mc: vector table of packets plus stall sequences,
// with a second instance built with STRIP_HEADER=1.
module tb_rx_libnet_mc;

  localparam int DW = 512;
  localparam int KW = 64;
  localparam int UW = 64;
  localparam int SEQ_LSB = 344;
  localparam int SYN_BIT = 377;
  localparam int CHAN_LSB = 378;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic [UW-1:0] u;
    logic          l;
  } beat_t;

  typedef struct {
    int          ch;
    logic [31:0] seq;
    bit          syn;
    int          nb;
    bit          fwd;
    bit          ackv;
    logic [39:0] ack;
    logic [31:0] drops;
  } vec_t;

  logic clk = 1'b0;
  logic resetn;
  logic [DW-1:0] rx_tdata;
  logic [KW-1:0] rx_tkeep;
  logic [UW-1:0] rx_tuser;
  logic rx_tlast, rx_tvalid, tx_tready, ack_tready, sel_s;

  logic m_rx_tready, m_tx_tlast, m_tx_tvalid, m_ack_tvalid;
  logic [DW-1:0] m_tx_tdata;
  logic [KW-1:0] m_tx_tkeep;
  logic [UW-1:0] m_tx_tuser;
  logic [39:0] m_ack_tdata;
  logic [31:0] m_drop;
  logic s_rx_tready, s_tx_tlast, s_tx_tvalid, s_ack_tvalid;
  logic [DW-1:0] s_tx_tdata;
  logic [KW-1:0] s_tx_tkeep;
  logic [UW-1:0] s_tx_tuser;
  logic [39:0] s_ack_tdata;
  logic [31:0] s_drop;

  logic c_rx_tready, c_tx_tlast, c_tx_tvalid, c_ack_tvalid;
  logic [DW-1:0] c_tx_tdata;
  logic [KW-1:0] c_tx_tkeep;
  logic [UW-1:0] c_tx_tuser;
  logic [39:0] c_ack_tdata;
  logic [31:0] c_drop;

  assign c_rx_tready  = sel_s ? s_rx_tready  : m_rx_tready;
  assign c_tx_tlast   = sel_s ? s_tx_tlast   : m_tx_tlast;
  assign c_tx_tvalid  = sel_s ? s_tx_tvalid  : m_tx_tvalid;
  assign c_tx_tdata   = sel_s ? s_tx_tdata   : m_tx_tdata;
  assign c_tx_tkeep   = sel_s ? s_tx_tkeep   : m_tx_tkeep;
  assign c_tx_tuser   = sel_s ? s_tx_tuser   : m_tx_tuser;
  assign c_ack_tvalid = sel_s ? s_ack_tvalid : m_ack_tvalid;
  assign c_ack_tdata  = sel_s ? s_ack_tdata  : m_ack_tdata;
  assign c_drop       = sel_s ? s_drop       : m_drop;

  always #5 clk = ~clk;

  rx_libnet_mc dut (
    .clk(clk), .resetn(resetn),
    .rx_tdata(rx_tdata), .rx_tkeep(rx_tkeep), .rx_tuser(rx_tuser), .rx_tlast(rx_tlast),
    .rx_tvalid(rx_tvalid && !sel_s), .rx_tready(m_rx_tready),
    .tx_tdata(m_tx_tdata), .tx_tkeep(m_tx_tkeep), .tx_tuser(m_tx_tuser), .tx_tlast(m_tx_tlast),
    .tx_tvalid(m_tx_tvalid), .tx_tready(tx_tready),
    .ack_tdata(m_ack_tdata), .ack_tvalid(m_ack_tvalid), .ack_tready(ack_tready),
    .drop_count(m_drop)
  );

  rx_libnet_mc #(.STRIP_HEADER(1'b1)) dut_s (
    .clk(clk), .resetn(resetn),
    .rx_tdata(rx_tdata), .rx_tkeep(rx_tkeep), .rx_tuser(rx_tuser), .rx_tlast(rx_tlast),
    .rx_tvalid(rx_tvalid && sel_s), .rx_tready(s_rx_tready),
    .tx_tdata(s_tx_tdata), .tx_tkeep(s_tx_tkeep), .tx_tuser(s_tx_tuser), .tx_tlast(s_tx_tlast),
    .tx_tvalid(s_tx_tvalid), .tx_tready(tx_tready),
    .ack_tdata(s_ack_tdata), .ack_tvalid(s_ack_tvalid), .ack_tready(ack_tready),
    .drop_count(s_drop)
  );

  int n_checks = 0;
  int n_errors = 0;
  int beat_id = 1;
  beat_t exp_tx[$];
  beat_t got_tx[$];
  logic [39:0] exp_ack[$];
  logic [39:0] got_ack[$];
  vec_t tbl[9];

  always @(posedge clk) begin
    if (resetn && c_tx_tvalid && tx_tready)
      got_tx.push_back('{d: c_tx_tdata, k: c_tx_tkeep, u: c_tx_tuser, l: c_tx_tlast});
    if (resetn && c_ack_tvalid && ack_tready) got_ack.push_back(c_ack_tdata);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drives one beat and returns at posedge+1 after it was accepted.
  task automatic send_beat(input beat_t b);
    int t = 0;
    rx_tdata = b.d; rx_tkeep = b.k; rx_tuser = b.u; rx_tlast = b.l; rx_tvalid = 1'b1;
    #1;
    while (!c_rx_tready && t < 200) begin
      @(posedge clk); #2; t++;
    end
    if (t >= 200) chk("rx_tready timeout", 64'(t), 64'(0));
    @(posedge clk); #1;
    rx_tvalid = 1'b0;
  endtask

  task automatic send_pkt(input int ch, input logic [31:0] seq, input bit syn, input int nb,
                          input bit fwd_hdr, input bit fwd_pay);
    beat_t b;
    for (int i = 0; i < nb; i++) begin
      b.d = '0;
      b.d[31:0] = beat_id;
      if (i == 0) begin
        b.d[CHAN_LSB +: 8] = ch[7:0];
        b.d[SEQ_LSB +: 32] = seq;
        b.d[SYN_BIT] = syn;
      end
      b.k = {beat_id[31:0], ~beat_id[31:0]};
      b.u = {~beat_id[31:0], beat_id[31:0]};
      b.l = (i == nb - 1);
      if ((i == 0 && fwd_hdr) || (i > 0 && fwd_pay)) exp_tx.push_back(b);
      beat_id++;
      send_beat(b);
    end
  endtask

  task automatic drain_check(input string name);
    int n;
    beat_t g, e;
    repeat (8) @(posedge clk);
    #1;
    chk($sformatf("%s tx beat count", name), 64'(got_tx.size()), 64'(exp_tx.size()));
    n = (got_tx.size() < exp_tx.size()) ? got_tx.size() : exp_tx.size();
    for (int i = 0; i < n; i++) begin
      g = got_tx.pop_front();
      e = exp_tx.pop_front();
      chk($sformatf("%s beat%0d tag", name, i), 64'(g.d[31:0]), 64'(e.d[31:0]));
      chk($sformatf("%s beat%0d data differs", name, i), 64'(g.d !== e.d), 64'(0));
      chk($sformatf("%s beat%0d keep", name, i), g.k, e.k);
      chk($sformatf("%s beat%0d user", name, i), g.u, e.u);
      chk($sformatf("%s beat%0d last", name, i), 64'(g.l), 64'(e.l));
    end
    got_tx.delete();
    exp_tx.delete();
    chk($sformatf("%s ack count", name), 64'(got_ack.size()), 64'(exp_ack.size()));
    n = (got_ack.size() < exp_ack.size()) ? got_ack.size() : exp_ack.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s ack%0d", name, i), 64'(got_ack.pop_front()), 64'(exp_ack.pop_front()));
    got_ack.delete();
    exp_ack.delete();
  endtask

  initial begin
    //          ch  seq           syn  nb fwd  ackv  ack              drops
    tbl[0] = '{0, 32'h0,        1'b0, 3, 1'b1, 1'b1, 40'h00_0000_0001, 32'd0};
    tbl[1] = '{2, 32'hFFFF_FFFF, 1'b1, 2, 1'b0, 1'b1, 40'h02_FFFF_FFFF, 32'd0};
    tbl[2] = '{2, 32'hFFFF_FFFF, 1'b0, 2, 1'b1, 1'b1, 40'h02_0000_0000, 32'd0};
    tbl[3] = '{1, 32'h5,        1'b0, 2, 1'b0, 1'b1, 40'h81_0000_0000, 32'd1};
    tbl[4] = '{0, 32'h1,        1'b0, 1, 1'b1, 1'b1, 40'h00_0000_0002, 32'd1};
    tbl[5] = '{7, 32'h0,        1'b0, 3, 1'b0, 1'b0, 40'h0,            32'd2};
    tbl[6] = '{3, 32'h0,        1'b0, 1, 1'b1, 1'b1, 40'h03_0000_0001, 32'd2};
    tbl[7] = '{1, 32'h0,        1'b0, 2, 1'b1, 1'b1, 40'h01_0000_0001, 32'd2};
    tbl[8] = '{1, 32'h0,        1'b0, 1, 1'b0, 1'b1, 40'h81_0000_0001, 32'd3};

    resetn = 1'b0; sel_s = 1'b0; rx_tvalid = 1'b0; rx_tlast = 1'b0;
    rx_tdata = '0; rx_tkeep = '0; rx_tuser = '0; tx_tready = 1'b1; ack_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset rx_tready", 64'(c_rx_tready), 64'(0));
    chk("reset tx_tvalid", 64'(c_tx_tvalid), 64'(0));
    chk("reset ack_tvalid", 64'(c_ack_tvalid), 64'(0));
    chk("reset drop_count", 64'(c_drop), 64'(0));
    resetn = 1'b1;
    @(posedge clk); #1;
    chk("post-reset rx_tready", 64'(c_rx_tready), 64'(1));

    for (int i = 0; i < 9; i++) begin
      send_pkt(tbl[i].ch, tbl[i].seq, tbl[i].syn, tbl[i].nb, tbl[i].fwd, tbl[i].fwd);
      if (tbl[i].ackv) exp_ack.push_back(tbl[i].ack);
      drain_check($sformatf("vec%0d", i));
      chk($sformatf("vec%0d drop_count", i), 64'(c_drop), 64'(tbl[i].drops));
    end

    // tx backpressure mid-packet: ch0 expects seq 2.
    exp_ack.push_back(40'h00_0000_0003);
    fork
      send_pkt(0, 32'h2, 1'b0, 10, 1'b1, 1'b1);
      begin
        int t;
        logic [31:0] held;
        t = 0;
        while (!c_tx_tvalid && t < 50) begin
          @(posedge clk); #1; t++;
        end
        repeat (2) @(posedge clk);
        #1;
        tx_tready = 1'b0;
        held = c_tx_tdata[31:0];
        repeat (5) begin
          @(posedge clk); #1;
          chk("stall tx_tvalid", 64'(c_tx_tvalid), 64'(1));
          chk("stall tx_tdata", 64'(c_tx_tdata[31:0]), 64'(held));
          chk("stall rx_tready", 64'(c_rx_tready), 64'(0));
        end
        repeat (12) begin
          tx_tready = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
        end
        tx_tready = 1'b1;
      end
    join
    drain_check("txstall");

    // Ack backpressure blocks the second header until the first ack is taken.
    ack_tready = 1'b0;
    exp_ack.push_back(40'h03_0000_0002);
    exp_ack.push_back(40'h03_0000_0003);
    fork
      begin
        send_pkt(3, 32'h1, 1'b0, 1, 1'b1, 1'b1);
        send_pkt(3, 32'h2, 1'b0, 1, 1'b1, 1'b1);
      end
      begin
        int t;
        t = 0;
        while (!c_ack_tvalid && t < 50) begin
          @(posedge clk); #1; t++;
        end
        repeat (4) begin
          @(posedge clk); #1;
          chk("ackstall rx_tready", 64'(c_rx_tready), 64'(0));
          chk("ackstall ack_tvalid", 64'(c_ack_tvalid), 64'(1));
          chk("ackstall ack_tdata", 64'(c_ack_tdata), 64'h03_0000_0002);
        end
        ack_tready = 1'b1;
      end
    join
    drain_check("ackstall");

    // Adjacent headers on one channel must see the freshly updated sequence.
    exp_ack.push_back(40'h03_0000_0004);
    exp_ack.push_back(40'h03_0000_0005);
    send_pkt(3, 32'h3, 1'b0, 1, 1'b1, 1'b1);
    send_pkt(3, 32'h4, 1'b0, 1, 1'b1, 1'b1);
    drain_check("adjacent");
    chk("final drop_count", 64'(c_drop), 64'(3));

    // STRIP_HEADER=1 instance: header beats never reach tx.
    sel_s = 1'b1;
    @(posedge clk); #1;
    exp_ack.push_back(40'h00_0000_0001);
    exp_ack.push_back(40'h00_0000_0002);
    send_pkt(0, 32'h0, 1'b0, 3, 1'b0, 1'b1);
    send_pkt(0, 32'h1, 1'b0, 1, 1'b0, 1'b1);
    drain_check("strip");
    chk("strip drop_count", 64'(c_drop), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
